// File: rtl/lsu.sv
// Load/store unit: one outstanding core request, one req/ack access to the data RAM.
// Handles little-endian lane selection, store replication, load extension and fault detection.
module lsu #(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  // Handshakes: core side accepts on req_valid && req_ready; RAM side holds mem_req
  // with stable mem_* until the edge where mem_ack is sampled high.
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e              state_q;
  logic                req_ready_q, resp_valid_q, resp_fault_q, mem_req_q, mem_we_q;
  logic [31:0]         resp_rdata_q, mem_wdata_q;
  logic [MEM_AW-1:0]   mem_addr_q;
  logic [3:0]          mem_be_q;
  logic                store_q;
  logic [2:0]          f3_q;
  logic [1:0]          off_q;

  logic                fault_d;
  logic [3:0]          be_d;
  logic [31:0]         wdata_d;
  logic [31:0]         shifted;
  logic [31:0]         load_d;
  logic                unused_addr;

  assign unused_addr = ^req_addr[31:MEM_AW+2];

  always_comb begin
    fault_d = 1'b0;
    if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111) fault_d = 1'b1;
    if (req_store && req_funct3[2]) fault_d = 1'b1;
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) fault_d = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) fault_d = 1'b1;
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Addressed byte/half is brought down to bit 0 before extension.
  assign shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_d = shifted;
    case (f3_q)
      3'b000:  load_d = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_d = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_d = {24'd0, shifted[7:0]};
      3'b101:  load_d = {16'd0, shifted[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'd0;
      mem_wdata_q  <= 32'd0;
      store_q      <= 1'b0;
      f3_q         <= 3'd0;
      off_q        <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            store_q     <= req_store;
            f3_q        <= req_funct3;
            off_q       <= req_addr[1:0];
            mem_addr_q  <= req_addr[MEM_AW+1:2];
            mem_be_q    <= be_d;
            mem_wdata_q <= wdata_d;
            req_ready_q <= 1'b0;
            if (fault_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else begin
              state_q   <= ACCESS;
              mem_req_q <= 1'b1;
              mem_we_q  <= req_store;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            state_q      <= RESP;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= store_q ? 32'd0 : load_d;
          end
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed plus randomized bench for lsu against an arithmetic reference model.
module tb_lsu;
  localparam int MEM_AW = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_store = 1'b0;
  logic [2:0]        req_funct3 = 3'd0;
  logic [31:0]       req_addr = 32'd0;
  logic [31:0]       req_wdata = 32'd0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_fault;
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack = 1'b0;
  logic [31:0]       mem_rdata = 32'd0;

  int checks = 0;
  int errors = 0;

  lsu #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model: plain arithmetic on access size and byte offset
  function automatic int unsigned size_of(input logic [2:0] f3);
    return (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
  endfunction

  function automatic bit model_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (st && f3 >= 3'd4) return 1'b1;
    return (a % size_of(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned n;
    n = size_of(f3);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (size_of(f3) == 1) return (wd % 256) * 32'h0101_0101;
    if (size_of(f3) == 2) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (a % 4));
    case (f3)
      3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
      3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
      3'd4: v = v % 256;
      3'd5: v = v % 65536;
      default: ;
    endcase
    return v;
  endfunction

  // driver: one full transaction with delay RAM wait cycles, checked every cycle
  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int delay);
    logic [31:0] exp_q[$];
    logic [31:0] exp_rdata;
    chk("ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    step();
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    if (model_fault(st, f3, a)) begin
      exp_q.push_back(32'd0);
      mem_ack = 1'($urandom_range(0, 1));
      chk("fault_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("fault_flag", {31'd0, resp_fault}, 32'd1);
      chk("fault_rdata", resp_rdata, exp_q[0]);
      chk("fault_no_mem_req", {31'd0, mem_req}, 32'd0);
      chk("fault_ready_low", {31'd0, req_ready}, 32'd0);
    end else begin
      exp_rdata = st ? 32'd0 : model_load(f3, a, rd);
      exp_q.push_back(exp_rdata);
      for (int i = 0; i <= delay; i++) begin
        chk("mem_req", {31'd0, mem_req}, 32'd1);
        chk("mem_we", {31'd0, mem_we}, {31'd0, st});
        chk("mem_addr", 32'(mem_addr), (a >> 2) % (1 << MEM_AW));
        chk("mem_be", {28'd0, mem_be}, {28'd0, model_be(f3, a)});
        chk("mem_wdata", mem_wdata, model_wdata(f3, wd));
        chk("ready_low_access", {31'd0, req_ready}, 32'd0);
        chk("no_early_resp", {31'd0, resp_valid}, 32'd0);
        req_valid = 1'($urandom_range(0, 1));
        req_addr = $urandom;
        mem_ack = (i == delay);
        mem_rdata = (i == delay) ? rd : $urandom;
        step();
      end
      mem_ack = 1'b0; req_valid = 1'b0;
      chk("resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("resp_fault", {31'd0, resp_fault}, 32'd0);
      chk("resp_rdata", resp_rdata, exp_q[0]);
      chk("mem_req_dropped", {31'd0, mem_req}, 32'd0);
      chk("ready_low_resp", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    step();
    mem_ack = 1'b0;
    chk("resp_single_pulse", {31'd0, resp_valid}, 32'd0);
    chk("ready_after_resp", {31'd0, req_ready}, 32'd1);
    chk("rdata_held", resp_rdata, exp_q.pop_front());
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    bit          st;
    step(); step();
    rst = 1'b0;
    // reset state
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);

    // directed steps
    run_op(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 32'h0, 0);
    chk("sw_addr_literal", 32'(mem_addr), 32'd4);
    chk("sw_be_literal", {28'd0, mem_be}, 32'hF);
    run_op(1'b0, 3'd0, 32'h13, 32'h0, 32'h80FF_1234, 0);
    chk("lb_literal", resp_rdata, 32'hFFFF_FF80);
    run_op(1'b0, 3'd4, 32'h13, 32'h0, 32'h80FF_1234, 0);
    chk("lbu_literal", resp_rdata, 32'h0000_0080);
    run_op(1'b0, 3'd1, 32'h12, 32'h0, 32'h80FF_1234, 1);
    chk("lh_literal", resp_rdata, 32'hFFFF_80FF);
    run_op(1'b0, 3'd5, 32'h12, 32'h0, 32'h80FF_1234, 0);
    chk("lhu_literal", resp_rdata, 32'h0000_80FF);
    run_op(1'b1, 3'd0, 32'h21, 32'h0000_00AB, 32'h0, 0);
    chk("sb_be_literal", {28'd0, mem_be}, 32'h2);
    chk("sb_wdata_literal", mem_wdata, 32'hABAB_ABAB);
    run_op(1'b1, 3'd1, 32'h22, 32'h0000_1234, 32'h0, 0);
    chk("sh_be_literal", {28'd0, mem_be}, 32'hC);
    chk("sh_wdata_literal", mem_wdata, 32'h1234_1234);
    run_op(1'b0, 3'd2, 32'h06, 32'h0, 32'h0, 0);
    run_op(1'b1, 3'd1, 32'h03, 32'h0, 32'h0, 0);
    run_op(1'b0, 3'd3, 32'h00, 32'h0, 32'h0, 0);
    run_op(1'b1, 3'd4, 32'h00, 32'h0, 32'h0, 0);
    run_op(1'b0, 3'd2, 32'h0000_1FFC, 32'h0, 32'h1357_9BDF, 3);
    chk("lw_wait_literal", resp_rdata, 32'h1357_9BDF);

    // reset during ACCESS with a late ack
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40;
    step();
    req_valid = 1'b0;
    chk("pre_rst_mem_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_no_resp", {31'd0, resp_valid}, 32'd0);
    step();
    mem_ack = 1'b0;
    chk("late_ack_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("late_ack_no_req", {31'd0, mem_req}, 32'd0);
    run_op(1'b0, 3'd2, 32'h44, 32'h0, 32'h0BAD_F00D, 1);

    // randomized transactions
    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom_range(0, 7));
      st = 1'($urandom_range(0, 1));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = (f3 % 4 == 1) ? {a[1], 1'b0} : 2'b00;
      if (f3 % 4 == 0 && $urandom_range(0, 1) == 1) a[1:0] = 2'($urandom);
      run_op(st, f3, a, $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
